// File: rtl/mar_access_sequencer.sv
// mar_access_sequencer
// Shares the MAR and the memory port between instruction fetch (address
// from PC) and operand access (address from MBR). Each transaction runs
// IDLE -> LOAD -> ACCESS -> DONE -> IDLE. Simultaneous requesters are served
// round-robin, and a stalled memory access is abandoned after TIMEOUT cycles.
// Every output is registered. Its next value is derived from the next state,
// so a strobe is high in the same cycle in which the FSM occupies its state.

module mar_access_sequencer #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int TMO_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              op_req,
  input  logic              op_we,
  input  logic [DATA_W-1:0] op_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mar_ld_pc,
  output logic              mar_ld_mbr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              fetch_done,
  output logic              op_done,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // The final ACCESS cycle that may still wait for mem_ready.
  localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TIMEOUT - 1);

  state_t              state;
  state_t              state_nxt;

  // Transaction context: who owns the port, and what it asked for.
  logic                gnt_op;
  logic                gnt_op_nxt;
  logic                last_op;
  logic                last_op_nxt;
  logic                we;
  logic                we_nxt;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   wdata_nxt;
  logic [TMO_W-1:0]    cnt;
  logic [TMO_W-1:0]    cnt_nxt;
  logic                tmo_nxt;
  logic [DATA_W-1:0]   rdata_nxt;

  // Round-robin choice among the requests that are present in IDLE.
  logic                pick_op;

  // Next register values for the outputs.
  logic                mar_ld_pc_d;
  logic                mar_ld_mbr_d;
  logic                mem_rd_d;
  logic                mem_wr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                fetch_done_d;
  logic                op_done_d;
  logic                busy_d;
  logic                timeout_err_d;

  // State register together with the per-transaction context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_op  <= 1'b0;
      last_op <= 1'b1;
      we      <= 1'b0;
      wdata   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      gnt_op  <= gnt_op_nxt;
      last_op <= last_op_nxt;
      we      <= we_nxt;
      wdata   <= wdata_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Arbitration: a single requester wins outright; when both requesters are
  // present, the one that was not granted last time wins.
  always_comb begin
    pick_op = op_req;
    if (fetch_req && op_req) begin
      pick_op = ~last_op;
    end
  end

  // Next-state logic, including the grant, the timeout count and read capture.
  always_comb begin
    state_nxt   = state;
    gnt_op_nxt  = gnt_op;
    last_op_nxt = last_op;
    we_nxt      = we;
    wdata_nxt   = wdata;
    cnt_nxt     = cnt;
    tmo_nxt     = 1'b0;
    rdata_nxt   = rdata;
    unique case (state)
      IDLE: begin
        if (fetch_req || op_req) begin
          state_nxt   = LOAD;
          gnt_op_nxt  = pick_op;
          last_op_nxt = pick_op;
          // A fetch is always a read; only an operand grant samples we/wdata.
          we_nxt      = pick_op ? op_we : 1'b0;
          wdata_nxt   = pick_op ? op_wdata : '0;
        end
      end
      LOAD: begin
        state_nxt = ACCESS;
        cnt_nxt   = '0;
      end
      ACCESS: begin
        cnt_nxt = cnt + 1'b1;
        if (mem_ready) begin
          // A ready on the last allowed cycle still counts as a completion.
          state_nxt = DONE;
          if (!we) begin
            rdata_nxt = mem_rdata;
          end
        end else if (cnt == CNT_LAST) begin
          state_nxt = DONE;
          tmo_nxt   = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the next state, so each registered strobe lines up
  // with the cycle spent in its state.
  always_comb begin
    mar_ld_pc_d   = (state_nxt == LOAD) && !gnt_op_nxt;
    mar_ld_mbr_d  = (state_nxt == LOAD) && gnt_op_nxt;
    mem_rd_d      = (state_nxt == ACCESS) && !we_nxt;
    mem_wr_d      = (state_nxt == ACCESS) && we_nxt;
    mem_wdata_d   = ((state_nxt == ACCESS) && we_nxt) ? wdata_nxt : '0;
    fetch_done_d  = (state_nxt == DONE) && !gnt_op_nxt;
    op_done_d     = (state_nxt == DONE) && gnt_op_nxt;
    timeout_err_d = tmo_nxt;
    busy_d        = (state_nxt != IDLE);
  end

  // Output registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_ld_pc   <= 1'b0;
      mar_ld_mbr  <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      rdata       <= '0;
      fetch_done  <= 1'b0;
      op_done     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mar_ld_pc   <= mar_ld_pc_d;
      mar_ld_mbr  <= mar_ld_mbr_d;
      mem_rd      <= mem_rd_d;
      mem_wr      <= mem_wr_d;
      mem_wdata   <= mem_wdata_d;
      rdata       <= rdata_nxt;
      fetch_done  <= fetch_done_d;
      op_done     <= op_done_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_mar_access_sequencer.sv
// tb_mar_access_sequencer
// Bench for mar_access_sequencer. The reference model is transaction-level:
// for each grant it derives the cycle offsets of LOAD, ACCESS and DONE from
// the ready delay and the timeout, tracks round-robin ownership and the last
// captured read value, and compares every output cycle by cycle.

module tb_mar_access_sequencer;

  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic          op_req;
  logic          op_we;
  logic [DW-1:0] op_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          mar_ld_pc;
  logic          mar_ld_mbr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rdata;
  logic          fetch_done;
  logic          op_done;
  logic          busy;
  logic          timeout_err;

  int            n_tests = 0;
  int            n_fail  = 0;

  // Model state: owner of the previous grant (1 = operand) and rdata.
  bit            last_op;
  logic [DW-1:0] exp_rdata;

  logic [7:0]    ctrl;
  assign ctrl = {mar_ld_pc, mar_ld_mbr, mem_rd, mem_wr,
                 fetch_done, op_done, timeout_err, busy};

  mar_access_sequencer #(.DATA_W(DW), .TIMEOUT(TO), .TMO_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .op_req      (op_req),
    .op_we       (op_we),
    .op_wdata    (op_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .mar_ld_pc   (mar_ld_pc),
    .mar_ld_mbr  (mar_ld_mbr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .rdata       (rdata),
    .fetch_done  (fetch_done),
    .op_done     (op_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // One transaction, started from an IDLE cycle. kind: 1 fetch, 2 operand,
  // 3 both. d = ACCESS cycles before mem_ready rises. rv = read data returned
  // on the completing cycle. drop_k = cycle after which requests drop.
  task automatic do_txn(input int kind, input bit we, input logic [DW-1:0] wd,
                        input int d, input logic [DW-1:0] rv, input int drop_k,
                        input bit noise);
    bit         wop;
    bit         weff;
    bit         tmo;
    bit         acc;
    int         n;
    int         dk;
    logic [7:0] exp_ctrl;
    logic [DW-1:0] exp_wd;
    wop  = (kind == 1) ? 1'b0 : (kind == 2) ? 1'b1 : !last_op;
    last_op = wop;
    weff = wop && we;
    tmo  = (d + 1 > TO);
    n    = tmo ? TO : d + 1;
    dk   = (drop_k < 1 || drop_k > 2 + n) ? 2 + n : drop_k;
    fetch_req = (kind == 1 || kind == 3);
    op_req    = (kind == 2 || kind == 3);
    op_we     = (kind == 1) ? 1'($urandom) : we;
    op_wdata  = (kind == 1) ? DW'($urandom) : wd;
    mem_ready = noise ? 1'($urandom) : 1'b0;
    mem_rdata = DW'($urandom);
    for (int k = 1; k <= 3 + n; k++) begin
      @(posedge clk); #1;
      acc = (k >= 2) && (k <= 1 + n);
      exp_ctrl = {k == 1 && !wop, k == 1 && wop, acc && !weff, acc && weff,
                  k == 2 + n && !wop, k == 2 + n && wop, k == 2 + n && tmo,
                  k >= 1 && k <= 2 + n};
      exp_wd = (acc && weff) ? wd : '0;
      if (k == 2 + n && !tmo && !weff) exp_rdata = rv;
      n_tests++;
      if (ctrl !== exp_ctrl) begin
        n_fail++;
        $display("FAIL txn_ctrl kind=%0d k=%0d got %b expected %b", kind, k, ctrl, exp_ctrl);
      end
      n_tests++;
      if (mem_wdata !== exp_wd) begin
        n_fail++;
        $display("FAIL txn_wdata kind=%0d k=%0d got %h expected %h", kind, k, mem_wdata, exp_wd);
      end
      n_tests++;
      if (rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL txn_rdata kind=%0d k=%0d got %h expected %h", kind, k, rdata, exp_rdata);
      end
      // Inputs for this cycle; operand inputs wander after the grant.
      op_we    = 1'($urandom);
      op_wdata = DW'($urandom);
      if (k == dk) begin
        fetch_req = 1'b0;
        op_req    = 1'b0;
      end
      if (k >= 2 && k <= 1 + n) mem_ready = (k >= d + 2);
      else mem_ready = noise ? 1'($urandom) : 1'b0;
      mem_rdata = (k == 1 + n && !tmo) ? rv : DW'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (ctrl !== 8'h00 || mem_wdata !== '0 || rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_values got ctrl=%b wdata=%h rdata=%h expected all 0", ctrl, mem_wdata, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_op = 1'b1;
    exp_rdata = '0;
    @(posedge clk); #1;
    n_tests++;
    if (ctrl !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_idle got ctrl=%b expected 00000000", ctrl);
    end
  endtask

  task automatic test_fetch_read();
    do_txn(1, 1'b0, 8'h00, 0, 8'h3C, -1, 1'b0);
  endtask

  task automatic test_op_write();
    do_txn(2, 1'b1, 8'hA5, 2, 8'h00, -1, 1'b0);
  endtask

  task automatic test_timeout();
    do_txn(2, 1'b0, 8'h00, 100, 8'h00, -1, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_ctrl;
    int p;
    bit g;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    last_op = 1'b1;
    exp_rdata = '0;
    fetch_req = 1'b1;
    op_req    = 1'b1;
    op_we     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 8'h77;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      p = c % 4;
      g = (((c - 1) / 4) % 2) == 1;
      exp_ctrl = {p == 1 && !g, p == 1 && g, p == 2, 1'b0,
                  p == 3 && !g, p == 3 && g, 1'b0, p != 0};
      if (c >= 3) exp_rdata = 8'h77;
      n_tests++;
      if (ctrl !== exp_ctrl) begin
        n_fail++;
        $display("FAIL rr_ctrl c=%0d got %b expected %b", c, ctrl, exp_ctrl);
      end
      n_tests++;
      if (rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL rr_rdata c=%0d got %h expected %h", c, rdata, exp_rdata);
      end
      if (c == 15) begin
        fetch_req = 1'b0;
        op_req    = 1'b0;
      end
    end
    last_op = 1'b1;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b0;
    op_req    = 1'b1;
    op_we     = 1'b0;
    mem_ready = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    n_tests++;
    if (mem_rd !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_before_reset got rd=%b busy=%b expected 1 1", mem_rd, busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (ctrl !== 8'h00 || mem_wdata !== '0 || rdata !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async got ctrl=%b wdata=%h rdata=%h expected all 0", ctrl, mem_wdata, rdata);
    end
    op_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_op = 1'b1;
    exp_rdata = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (ctrl !== 8'h00) begin
        n_fail++;
        $display("FAIL mid_after_release c=%0d got ctrl=%b expected 00000000", c, ctrl);
      end
    end
  endtask

  task automatic test_drop_in_load();
    do_txn(2, 1'b0, 8'h00, 1, 8'h5A, 1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (ctrl !== 8'h00) begin
        n_fail++;
        $display("FAIL drop_no_regrant c=%0d got ctrl=%b expected 00000000", c, ctrl);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      do_txn(int'($urandom_range(1, 3)), 1'($urandom), DW'($urandom),
             int'($urandom_range(0, 18)), DW'($urandom),
             int'($urandom_range(1, 22)), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    do_txn(1, 1'b0, 8'h00, 0, 8'h11, -1, 1'b0);
    do_txn(2, 1'b1, 8'h22, 0, 8'h00, -1, 1'b0);
    do_txn(3, 1'b0, 8'h00, 0, 8'h33, -1, 1'b0);
    do_txn(3, 1'b1, 8'h44, 14, 8'h55, -1, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    fetch_req = 1'b0;
    op_req    = 1'b0;
    op_we     = 1'b0;
    op_wdata  = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    last_op   = 1'b1;
    exp_rdata = '0;
    test_reset();
    test_fetch_read();
    test_op_write();
    test_timeout();
    test_back_to_back();
    test_drop_in_load();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
